// File: rtl/conv_result_frame_writer.sv
`default_nettype none
// ============================================================================
// Module   : conv_result_frame_writer
// Purpose  : Frame sink for the 3x3 stride-1 convolution output stream.
//            It writes one (IMG_WIDTH-2) x (IMG_HEIGHT-2) frame of float32
//            results into an internal buffer in row-major order, raises
//            Frame_Done while a full frame is held, and provides a
//            registered random-access read port.
// Ports    : clk, rst             - clock, synchronous active-high reset
//            Data_In, Valid_In    - result stream from the convolution core
//            Frame_Ack            - consumer releases the frame and re-arms capture
//            Rd_En, Rd_Addr       - read request, address = row*OUT_W + col
//            Rd_Data, Rd_Valid    - registered read data, valid one cycle later
//            Frame_Done           - level, high while a complete frame is held
//            Wr_Count             - words captured in the current frame
//            Overflow             - sticky, a word arrived while the frame was full
// Options  : CAPTURE_RELU_EN      - when defined, words with the sign bit set are
//                                   stored as zero (ReLU fused into capture)
// Revision : 1.0 - initial release
// ============================================================================
module conv_result_frame_writer #(
  parameter int DATA_WIDHT = 32,
  parameter int IMG_WIDTH  = 220,
  parameter int IMG_HEIGHT = 220,
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDHT-1:0] Data_In,
  input  logic                  Valid_In,
  input  logic                  Frame_Ack,
  input  logic                  Rd_En,
  input  logic [ADDR_WIDTH-1:0] Rd_Addr,
  output logic [DATA_WIDHT-1:0] Rd_Data,
  output logic                  Rd_Valid,
  output logic                  Frame_Done,
  output logic [ADDR_WIDTH:0]   Wr_Count,
  output logic                  Overflow
);

  localparam int OUT_W = IMG_WIDTH - 2;
  localparam int OUT_H = IMG_HEIGHT - 2;
  localparam int DEPTH = OUT_W * OUT_H;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [ADDR_WIDTH-1:0] COL_LAST = ADDR_WIDTH'(OUT_W - 1);
  localparam logic [ADDR_WIDTH-1:0] ROW_LAST = ADDR_WIDTH'(OUT_H - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);

  typedef enum logic [0:0] {
    S_CAPTURE = 1'b0,
    S_DONE    = 1'b1
  } state_t;

  state_t state, next_state;

  logic [ADDR_WIDTH-1:0] col;
  logic [ADDR_WIDTH-1:0] row;

  logic do_write;
  logic do_clear;
  logic set_ovf;
  logic last_word;

  logic [DATA_WIDHT-1:0] wr_data;
  logic [DATA_WIDHT-1:0] mem [DEPTH];

`ifdef CAPTURE_RELU_EN
  // Any word with the sign bit set (negatives, -0, negative NaN) becomes +0.
  assign wr_data = Data_In[DATA_WIDHT-1] ? '0 : Data_In;
`else
  assign wr_data = Data_In;
`endif

  assign last_word = (col == COL_LAST) && (row == ROW_LAST);

  // --------------------------------------------------------------------------
  // Capture FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_CAPTURE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    do_write   = 1'b0;
    do_clear   = 1'b0;
    set_ovf    = 1'b0;
    case (state)
      S_CAPTURE: begin
        // Frame_Ack is meaningless here and is ignored.
        if (Valid_In) begin
          do_write = 1'b1;
          if (last_word) begin
            next_state = S_DONE;
          end
        end
      end
      S_DONE: begin
        // Ack wins over a simultaneous word: the word is dropped and the
        // overflow flag ends up cleared.
        if (Frame_Ack) begin
          do_clear   = 1'b1;
          next_state = S_CAPTURE;
        end else if (Valid_In) begin
          set_ovf = 1'b1;
        end
      end
      default: begin
        next_state = S_CAPTURE;
      end
    endcase
  end

  assign Frame_Done = (state == S_DONE);

  // --------------------------------------------------------------------------
  // Position counters. Wr_Count doubles as the running write address, which
  // always equals row*OUT_W + col, so no multiplier is needed.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      Wr_Count <= '0;
      Overflow <= 1'b0;
    end else begin
      if (do_clear) begin
        col      <= '0;
        row      <= '0;
        Wr_Count <= '0;
        Overflow <= 1'b0;
      end else begin
        if (do_write) begin
          Wr_Count <= Wr_Count + 1'b1;
          if (col == COL_LAST) begin
            col <= '0;
            row <= row + 1'b1;
          end else begin
            col <= col + 1'b1;
          end
        end
        if (set_ovf) begin
          Overflow <= 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame buffer: one write port, one registered read port. Contents survive
  // reset. Both ports use non-blocking updates, so a same-address read and
  // write in one cycle returns the old word.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (do_write) begin
      mem[Wr_Count[IDX_W-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      Rd_Data  <= '0;
      Rd_Valid <= 1'b0;
    end else begin
      Rd_Valid <= Rd_En;
      if (Rd_En) begin
        if ({1'b0, Rd_Addr} >= DEPTH_W) begin
          Rd_Data <= '0;
        end else begin
          Rd_Data <= mem[Rd_Addr[IDX_W-1:0]];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/conv_result_frame_writer.md
Name: conv_result_frame_writer

Overview:
- Sink at the far end of the convolution output stream; the producer is the 3x3 stride-1 convolution core.
- Captures one frame of (IMG_WIDTH-2) x (IMG_HEIGHT-2) float32 results, written in row-major order on each Valid_In, into an internal frame buffer.
- Flags frame completion. Exposes a registered random-access read port so downstream layers or the host can fetch results by address.

Parameters:
- DATA_WIDHT, 32, word width (IEEE-754 single).
- IMG_WIDTH, 220, input image width. Output width OUT_W = IMG_WIDTH-2 (localparam).
- IMG_HEIGHT, 220, input image height. Output height OUT_H = IMG_HEIGHT-2 (localparam).
- ADDR_WIDTH, 16, buffer address width. Must satisfy 2^ADDR_WIDTH >= OUT_W*OUT_H.

Ports:
- clk, input, 1, single clock; everything is rising-edge.
- rst, input, 1, synchronous active-high reset.
- Data_In, input, DATA_WIDHT, result word from the convolution Data_Out.
- Valid_In, input, 1, qualifies Data_In; driven by the convolution Valid_Out.
- Frame_Ack, input, 1, consumer releases the buffer and re-arms capture.
- Rd_En, input, 1, read request.
- Rd_Addr, input, ADDR_WIDTH, read address (row*OUT_W + col).
- Rd_Data, output, DATA_WIDHT, registered read data.
- Rd_Valid, output, 1, Rd_Data qualifier.
- Frame_Done, output, 1, level; high while a complete frame is held.
- Wr_Count, output, ADDR_WIDTH+1, number of words captured in the current frame.
- Overflow, output, 1, sticky; Valid_In was seen while in DONE.

Behaviour:
- Reset:
  - state=CAPTURE; col, row, Wr_Count = 0.
  - Frame_Done=0, Overflow=0, Rd_Valid=0, Rd_Data=0.
  - Buffer contents are not cleared.
  - Reset mid-frame discards the partial frame; the next Valid_In is written to address 0.
- CAPTURE state:
  - Each cycle with Valid_In=1: mem[row*OUT_W+col] <= Data_In; Wr_Count += 1.
  - col increments. At col=OUT_W-1, col wraps to 0 and row increments.
  - The address is a running counter; no multiplier is used.
  - Valid_In=0 holds all counters; gaps of any length are allowed.
  - Write of the word at row=OUT_H-1, col=OUT_W-1: the state moves to DONE on that edge, so Frame_Done=1 from the next cycle. Wr_Count = OUT_W*OUT_H.
  - Frame_Ack in CAPTURE is ignored.
- DONE state:
  - Valid_In does not write the buffer; it sets Overflow=1 (sticky).
  - Frame_Ack=1: on the next edge, state returns to CAPTURE; col, row, Wr_Count = 0; Frame_Done=0; Overflow=0.
  - Frame_Ack and Valid_In in the same cycle in DONE: that word is dropped and Overflow ends cleared. Ack has priority.
- Read port (independent of state):
  - Latency 1: Rd_Valid(t+1) = Rd_En(t).
  - Rd_Data(t+1) = mem[Rd_Addr(t)].
  - Rd_Data holds its value when Rd_En=0.
  - Rd_Addr >= OUT_W*OUT_H: Rd_Data=0, Rd_Valid=1.
  - Read and write to the same address in the same cycle: read-first, returns the old contents.
- Buffer: single write port and single read port, depth OUT_W*OUT_H, inferred as block RAM.

Optional Feature:
- Macro: CAPTURE_RELU_EN.
- Defined: on write, any word with sign bit 1 (negative or -0) is stored as 32'h00000000, which fuses ReLU into capture. NaN with sign 1 is also zeroed.
- Undefined: words are stored bit-exact.
- Latency and counters are identical either way.

Test Plan:
- IMG_WIDTH=IMG_HEIGHT=5 (OUT_W=OUT_H=3), 9 contiguous Valid_In words 32'h3f800000..+8 -> Frame_Done rises the cycle after the 9th write, Wr_Count=9. Reads of addr 0..8 return the same words with 1-cycle latency.
- Same stream with Valid_In deasserted for 3 cycles between every word -> identical buffer contents; Frame_Done only after the 9th valid word.
- In DONE, drive 2 extra Valid_In words 32'hdeadbeef -> Overflow=1 and buffer unchanged. Frame_Ack -> Overflow=0, Frame_Done=0, Wr_Count=0. A new frame overwrites from addr 0.
- Assert rst after 4 of 9 words, then send 9 words 32'h40000000.. -> addr 0 holds 32'h40000000, Frame_Done after the 9th.
- Rd_Addr=9 with Rd_En=1 -> Rd_Data=0, Rd_Valid=1. Read and write of addr 2 in the same cycle -> old value returned.
- With CAPTURE_RELU_EN defined, write 32'hc0000000 at addr 0 -> read returns 32'h00000000; without the macro it returns 32'hc0000000.
